seq_pattern_fsm: RTL and testbench
==================================

# seq_pattern_fsm

Parametrised serial pattern-detector FSM, the successor to the two- and three-state teaching FSMs. It consumes a qualified one-bit stream and recognises a configurable PATTERN_W-bit pattern, sent MSB first. Overlap handling and Moore/Mealy output style are selectable at elaboration time. It exposes the current match-progress state and a saturating match counter for debug and observability in the lab designs.

## Interface
- PATTERN_W, 4: pattern length in bits; legal range 1..16.
- PATTERN, 4'b1011: pattern to detect; bit PATTERN_W-1 is the first expected bit.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = detection restarts from empty after a match.
- MEALY, 0: 0 = Moore output (registered state); 1 = Mealy output (combinational on the accepted bit).
- CNT_W, 8: width of the match counter.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  synchronous clear of state and counter.
- in_valid  in  1  in_bit is accepted on this edge when high.
- in_bit  in  1  serial data bit.
- state  out  SW  number of pattern bits currently matched.
  - SW = $clog2(PATTERN_W+1).
  - Range is 0..PATTERN_W in Moore mode and 0..PATTERN_W-1 in Mealy mode.
- match  out  1  match indication (see Operation).
- match_cnt  out  CNT_W  total matches since reset or clear; saturating.

## Operation
- State meaning: k = length of the longest pattern prefix that is a suffix of the accepted bits.
- The transition function delta(k, b) is KMP-style: the longest prefix of PATTERN that is a suffix of (prefix_k followed by b).
  - It is computed at elaboration by a constant function; there is no runtime table memory.
- border = length of the longest proper prefix of PATTERN that is also a suffix of it (0 for 1011 is wrong: border(1011) = 1).
- Cycles with in_valid = 0: state, match_cnt and the Moore match output hold; Mealy match = 0.
- Mealy (MEALY=1):
  - match = in_valid & !clear & (delta(state, in_bit) == PATTERN_W).
  - On a match, next state = border if OVERLAP, else 0.
  - Otherwise, next state = delta(state, in_bit).
- Moore (MEALY=0):
  - match = (state == PATTERN_W).
  - From state PATTERN_W, the next accepted bit moves to delta(border, b) if OVERLAP, else delta(0, b).
  - All other states move to delta(state, b).
- match_cnt increments by 1 on every match event and saturates at 2^CNT_W-1 (no wrap).
  - Mealy: the event is the cycle match is high.
  - Moore: the event is the edge that enters state PATTERN_W.
- clear: on the next edge, state = 0 and match_cnt = 0.
  - clear has priority over in_valid; the bit presented with clear is discarded and no count is taken.
- PATTERN_W = 1: Moore uses states 0/1; Mealy stays in state 0 and matches combinationally.

## Timing
- Reset values: state = 0, match_cnt = 0, match = 0 (Moore; Mealy match is also 0 while rst is high).
- rst asserted mid-pattern: partial progress is discarded immediately (asynchronous); the first bit after release starts from state 0.
- Mealy latency: match is in the same cycle as the final pattern bit; match_cnt updates on that edge.
- Moore latency: match rises one cycle after the edge accepting the final bit and stays high until the next accepted bit or clear.
- One bit per clock maximum; no backpressure; no internal buffering.
- Back-to-back matches: with overlap, a pattern with border b can rematch after PATTERN_W-b further bits.

## Test plan
- Mealy, OVERLAP=1, PATTERN=1011: feed 1,0,1,1,0,1,1 with in_valid=1 continuously.
  - Required: match high on bits 4 and 7; match_cnt = 2; final state = 1.
- Same stimulus with OVERLAP=0.
  - Required: match only on bit 4; match_cnt = 1; final state = 1.
- Moore, OVERLAP=1: feed 1,0,1,1, then hold in_valid=0 for 3 cycles, then feed 0.
  - Required: state = 4 and match = 1 from the cycle after bit 4 through the idle cycles.
  - Required: after the 0 bit, state = 2 and match = 0.
- Gapped input: 1,(idle),0,(idle),1,(idle),1 in Mealy mode.
  - Required: state steps 1,1,2,2,3,3, then match on the last bit.
- Saturation, CNT_W=2, Mealy overlap: feed 1011 repeated 5 times (20 bits, with overlap yielding at least 5 matches).
  - Required: match_cnt stops at 3.
- Reset and clear:
  - Assert rst asynchronously at state 3. Required: state = 0 immediately; the next 1 bit gives state 1.
  - Assert clear together with a matching final bit. Required: no match pulse, match_cnt = 0, state = 0.

Source files
------------

// File: rtl/seq_pattern_fsm.sv
// Serial pattern detector: tracks the longest matched pattern prefix using a
// transition table built at elaboration, with selectable overlap and Moore/Mealy output.
module seq_pattern_fsm #(
  parameter int unsigned          PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter bit                   MEALY     = 1'b0,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic                           in_bit,
  output logic [$clog2(PATTERN_W+1)-1:0] state,
  output logic                           match,
  output logic [CNT_W-1:0]               match_cnt
);

  localparam int unsigned SW    = $clog2(PATTERN_W + 1);
  localparam int          PW    = int'(PATTERN_W);
  localparam int unsigned TBL_N = 2 ** (SW + 1);

  // Bit i of the pattern counted from the first transmitted bit.
  function automatic int pbit_f(input int i);
    logic [PATTERN_W-1:0] t;
    t = PATTERN >> (PW - 1 - i);
    return int'(t[0]);
  endfunction

  // Longest pattern prefix that is a suffix of (prefix_k followed by b).
  function automatic int delta_f(input int k, input int b);
    int best;
    int j;
    int sb;
    bit ok;
    best = 0;
    for (int l = 1; l <= PW; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++) begin
          j = k + 1 - l + i;
          if (j == k) sb = b;
          else        sb = pbit_f(j);
          if (sb != pbit_f(i)) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int border_f();
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < PW; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++)
        if (pbit_f(i) != pbit_f(PW - l + i)) ok = 1'b0;
      if (ok) best = l;
    end
    return best;
  endfunction

  localparam int BORDER = border_f();

  // Constant transition table indexed by {state, bit}; unreachable rows are zero.
  logic [SW-1:0] tbl [TBL_N];

  for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
    if ((g / 2) <= PW) begin : g_v
      localparam int D = delta_f(g / 2, g % 2);
      assign tbl[g] = SW'(D);
    end else begin : g_z
      assign tbl[g] = '0;
    end
  end

  logic [SW-1:0]    eff_k;
  logic [SW-1:0]    d;
  logic             hit;
  logic [SW-1:0]    state_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next-state and counter logic; a full Moore state restarts from the border or empty.
  always_comb begin
    eff_k     = state;
    d         = '0;
    hit       = 1'b0;
    state_nxt = state;
    cnt_nxt   = match_cnt;
    if (!MEALY && (state == SW'(PATTERN_W)))
      eff_k = OVERLAP ? SW'(BORDER) : '0;
    d   = tbl[{eff_k, in_bit}];
    hit = in_valid && !clear && (d == SW'(PATTERN_W));
    if (clear) begin
      state_nxt = '0;
      cnt_nxt   = '0;
    end else if (in_valid) begin
      state_nxt = d;
      if (MEALY && hit)
        state_nxt = OVERLAP ? SW'(BORDER) : '0;
      if (hit && (match_cnt != '1))
        cnt_nxt = match_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= cnt_nxt;
    end
  end

  assign match = MEALY ? (hit && !rst) : (state == SW'(PATTERN_W));

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// Bench for seq_pattern_fsm: several parameter sets share one input stream and are
// checked against a history-based model of the pattern rules.
module tb_seq_pattern_fsm;

  localparam int NI = 8;
  localparam int PW_A  [NI] = '{4, 4, 4, 4, 4, 1, 1, 5};
  localparam int PAT_A [NI] = '{11, 11, 11, 11, 11, 1, 0, 21};
  localparam int CW_A  [NI] = '{8, 8, 8, 8, 2, 8, 8, 8};
  localparam bit OVL_A [NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam bit MLY_A [NI] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic in_valid;
  logic in_bit;

  always #5 clk = ~clk;

  logic [7:0] o_st  [NI];
  logic       o_m   [NI];
  logic [7:0] o_cnt [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W  = PW_A[g];
    localparam int CW = CW_A[g];
    localparam logic [W-1:0] P = W'(PAT_A[g]);
    logic [$clog2(W+1)-1:0] st;
    logic                   m;
    logic [CW-1:0]          cnt;
    seq_pattern_fsm #(
      .PATTERN_W(W), .PATTERN(P), .OVERLAP(OVL_A[g]), .MEALY(MLY_A[g]), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
      .state(st), .match(m), .match_cnt(cnt)
    );
    assign o_st[g]  = 8'(st);
    assign o_m[g]   = m;
    assign o_cnt[g] = 8'(cnt);
  end

  // Model: recent accepted bits, their count, match counter, and "just matched" flag.
  logic [31:0] hb [NI];
  int          hl [NI];
  int          cnt_m [NI];
  bit          jm [NI];

  int ntotal = 0;
  int npass  = 0;
  int nfail  = 0;

  // Longest pattern prefix (up to maxl bits) that ends the recorded history.
  function automatic int lps(input logic [31:0] h, input int len, input int pw,
                             input int pat, input int maxl);
    int best = 0;
    logic [31:0] mask;
    for (int l = 1; l <= maxl; l++) begin
      mask = (32'd1 << l) - 32'd1;
      if (l <= len && (h & mask) == 32'(pat >> (pw - l))) best = l;
    end
    return best;
  endfunction

  function automatic bit full_after(input int i, input logic b);
    logic [31:0] h2;
    int l2;
    h2 = {hb[i][30:0], b};
    l2 = ((!OVL_A[i] && jm[i]) ? 0 : hl[i]) + 1;
    return lps(h2, l2, PW_A[i], PAT_A[i], PW_A[i]) == PW_A[i];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NI; i++) begin
      hb[i] = '0; hl[i] = 0; cnt_m[i] = 0; jm[i] = 1'b0;
    end
  endtask

  // Apply the current inputs to the model as the coming rising edge would.
  task automatic model_update();
    bit f;
    for (int i = 0; i < NI; i++) begin
      if (clear) begin
        hl[i] = 0; cnt_m[i] = 0; jm[i] = 1'b0;
      end else if (in_valid) begin
        f = full_after(i, in_bit);
        if (!OVL_A[i] && jm[i]) hl[i] = 0;
        hb[i] = {hb[i][30:0], in_bit};
        hl[i] = (hl[i] < 32) ? hl[i] + 1 : 32;
        if (f) begin
          if (cnt_m[i] < (1 << CW_A[i]) - 1) cnt_m[i]++;
          if (MLY_A[i] && !OVL_A[i]) hl[i] = 0;
        end
        jm[i] = f;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int est;
    bit em;
    for (int i = 0; i < NI; i++) begin
      if (MLY_A[i]) begin
        est = lps(hb[i], hl[i], PW_A[i], PAT_A[i], PW_A[i] - 1);
        em  = !rst && in_valid && !clear && full_after(i, in_bit);
      end else begin
        est = lps(hb[i], hl[i], PW_A[i], PAT_A[i], PW_A[i]);
        em  = (est == PW_A[i]);
      end
      chk($sformatf("i%0d state", i), 32'(o_st[i]), est);
      chk($sformatf("i%0d match", i), 32'(o_m[i]), 32'(em));
      chk($sformatf("i%0d cnt", i), 32'(o_cnt[i]), cnt_m[i]);
    end
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v; in_bit = b; clear = c;
    #1;
    check_all();
    model_update();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    #1;
    reset_model();
    check_all();
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;

    // Overlap vs non-overlap Mealy on 1011011
    seq = 4'b1011;
    for (int k = 0; k < 4; k++) step(1'b1, seq[3-k], 1'b0);
    chk("tp1 match bit4 ovl", 32'(o_m[0]), 1);
    chk("tp1 match bit4 novl", 32'(o_m[1]), 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("tp1 match bit7 ovl", 32'(o_m[0]), 1);
    chk("tp1 no match bit7 novl", 32'(o_m[1]), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("tp1 cnt ovl", 32'(o_cnt[0]), 2);
    chk("tp1 state ovl", 32'(o_st[0]), 1);
    chk("tp1 cnt novl", 32'(o_cnt[1]), 1);
    chk("tp1 state novl", 32'(o_st[1]), 1);

    // Moore hold through idle cycles, then restart from the border
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, seq[3-k], 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("moore idle state", 32'(o_st[2]), 4);
      chk("moore idle match", 32'(o_m[2]), 1);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("moore after0 state", 32'(o_st[2]), 2);
    chk("moore after0 match", 32'(o_m[2]), 0);

    // Gapped Mealy input
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, seq[3-k], 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("gap state", 32'(o_st[0]), k + 1);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("gap final match", 32'(o_m[0]), 1);

    // Counter saturation with narrow counter
    step(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 4; k++) step(1'b1, seq[3-k], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sat cnt narrow", 32'(o_cnt[4]), 3);
    chk("sat cnt wide", 32'(o_cnt[0]), 5);

    // Asynchronous reset mid-pattern
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, seq[3-k], 1'b0);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    #1;
    chk("pre-rst state mealy", 32'(o_st[0]), 3);
    chk("pre-rst state moore", 32'(o_st[2]), 3);
    rst = 1'b1;
    #1;
    reset_model();
    chk("async rst state mealy", 32'(o_st[0]), 0);
    chk("async rst state moore", 32'(o_st[2]), 0);
    chk("async rst cnt", 32'(o_cnt[0]), 0);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("post-rst state", 32'(o_st[0]), 1);

    // Clear presented with a would-be matching bit
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, seq[3-k], 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("pre-clear cnt", 32'(o_cnt[0]), 1);
    chk("pre-clear state", 32'(o_st[0]), 3);
    step(1'b1, 1'b1, 1'b1);
    chk("clear suppresses match", 32'(o_m[0]), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("clear cnt", 32'(o_cnt[0]), 0);
    chk("clear state", 32'(o_st[0]), 0);

    // Randomized stream with occasional clears
    for (int n = 0; n < 800; n++)
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 59) == 0));
    step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
